// File: rtl/pixel_mean_divider.sv
// Mean-pixel divider: truncating sum/count via a restoring divider, one quotient
// bit per clock, with the result clamped to OUT_W bits and a divide-by-zero flag.
module pixel_mean_divider #(
  parameter int SUM_W = 22,
  parameter int CNT_W = 14,
  parameter int OUT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [SUM_W-1:0] sum_in,
  input  logic [CNT_W-1:0] count_in,
  output logic             busy,
  output logic             done,
  output logic [OUT_W-1:0] avg,
  output logic             sat,
  output logic             div_zero
);

  localparam int BIT_W = $clog2(SUM_W);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(SUM_W - 1);

  typedef enum logic [1:0] {IDLE, DIV, FIN} state_t;

  state_t           state;
  logic [SUM_W-1:0] dividend;
  logic [SUM_W-1:0] quotient;
  logic [CNT_W-1:0] divisor;
  logic [CNT_W:0]   remainder;
  logic [BIT_W-1:0] bit_cnt;

  // The remainder stays below the divisor, so its low CNT_W bits plus the next
  // dividend bit form the trial value without losing anything.
  logic [CNT_W:0] trial;
  logic           fits;

  always_comb begin
    trial = {remainder[CNT_W-1:0], dividend[SUM_W-1]};
    fits  = (trial >= {1'b0, divisor});
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      dividend  <= '0;
      quotient  <= '0;
      divisor   <= '0;
      remainder <= '0;
      bit_cnt   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      avg       <= '0;
      sat       <= 1'b0;
      div_zero  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (count_in == '0) begin
              avg      <= '1;
              div_zero <= 1'b1;
              sat      <= 1'b0;
              done     <= 1'b1;
            end else begin
              dividend  <= sum_in;
              divisor   <= count_in;
              remainder <= '0;
              quotient  <= '0;
              bit_cnt   <= LAST_BIT;
              busy      <= 1'b1;
              sat       <= 1'b0;
              div_zero  <= 1'b0;
              state     <= DIV;
            end
          end
        end

        DIV: begin
          remainder <= fits ? (trial - {1'b0, divisor}) : trial;
          quotient  <= {quotient[SUM_W-2:0], fits};
          dividend  <= {dividend[SUM_W-2:0], 1'b0};
          if (bit_cnt == '0) begin
            state <= FIN;
          end else begin
            bit_cnt <= bit_cnt - 1'b1;
          end
        end

        FIN: begin
          // Any quotient bit above the output width means the mean saturates.
          if (|quotient[SUM_W-1:OUT_W]) begin
            avg <= '1;
            sat <= 1'b1;
          end else begin
            avg <= quotient[OUT_W-1:0];
            sat <= 1'b0;
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_mean_divider.sv
// Scoreboard bench for pixel_mean_divider: expected means are queued at start
// and compared whenever the divider pulses done.
module tb_pixel_mean_divider;

  logic        clk;
  logic        reset;
  logic        start;
  logic [21:0] sum_in;
  logic [13:0] count_in;
  logic        busy;
  logic        done;
  logic [7:0]  avg;
  logic        sat;
  logic        div_zero;

  typedef struct {
    logic [7:0] avg;
    logic       sat;
    logic       dz;
  } exp_t;

  exp_t scoreboard[$];
  exp_t lastExp;
  int   errorCount = 0;
  int   checkCount = 0;

  pixel_mean_divider #(.SUM_W(22), .CNT_W(14), .OUT_W(8)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .sum_in(sum_in),
    .count_in(count_in),
    .busy(busy),
    .done(done),
    .avg(avg),
    .sat(sat),
    .div_zero(div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  function automatic exp_t modelMean(input logic [21:0] s, input logic [13:0] c);
    exp_t e;
    int unsigned q;
    if (c == 0) begin
      e.avg = 8'hFF; e.sat = 1'b0; e.dz = 1'b1;
    end else begin
      q = int'(s) / int'(c);
      if (q > 255) begin
        e.avg = 8'hFF; e.sat = 1'b1;
      end else begin
        e.avg = q[7:0]; e.sat = 1'b0;
      end
      e.dz = 1'b0;
    end
    return e;
  endfunction

  // Every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (reset && done) begin
      if (scoreboard.size() == 0) begin
        checkOutput("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = scoreboard.pop_front();
        checkOutput("avg", {24'd0, avg}, {24'd0, e.avg});
        checkOutput("sat", {31'd0, sat}, {31'd0, e.sat});
        checkOutput("div_zero", {31'd0, div_zero}, {31'd0, e.dz});
      end
    end
  end

  task automatic applyStimulus(input logic [21:0] s, input logic [13:0] c);
    @(negedge clk);
    sum_in   = s;
    count_in = c;
    start    = 1'b1;
    lastExp  = modelMean(s, c);
    scoreboard.push_back(lastExp);
    @(negedge clk);
    start    = 1'b0;
    sum_in   = 22'($urandom);
    count_in = 14'($urandom);
  endtask

  // Runs one division and checks latency, busy width and the single-cycle done.
  task automatic runDivision(input logic [21:0] s, input logic [13:0] c, input int pokeAt);
    int n;
    int busyCnt;
    int expLat;
    expLat = (c == 0) ? 0 : 23;
    applyStimulus(s, c);
    n = 0;
    busyCnt = 0;
    forever begin
      if (done) break;
      if (busy) busyCnt++;
      if (n == pokeAt) begin
        start = 1'b1; sum_in = 22'd99; count_in = 14'd1;
      end
      if (n == pokeAt + 1) start = 1'b0;
      if (n >= 60) begin
        checkOutput("done_timeout", 32'(n), 32'(expLat));
        break;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    checkOutput("latency", 32'(n), 32'(expLat));
    checkOutput("busy_cycles", 32'(busyCnt), 32'(expLat));
    @(negedge clk);
    checkOutput("done_pulse", {31'd0, done}, 32'd0);
  endtask

  initial begin
    reset    = 1'b0;
    start    = 1'b0;
    sum_in   = '0;
    count_in = '0;
    repeat (3) @(negedge clk);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_done", {31'd0, done}, 32'd0);
    checkOutput("rst_avg", {24'd0, avg}, 32'd0);
    checkOutput("rst_sat", {31'd0, sat}, 32'd0);
    checkOutput("rst_dz", {31'd0, div_zero}, 32'd0);
    reset = 1'b1;

    runDivision(22'd1000, 14'd8, -5);
    runDivision(22'd4177665, 14'd16383, -5);
    runDivision(22'd7, 14'd3, -5);
    runDivision(22'd600, 14'd2, -5);
    repeat (3) @(negedge clk);
    checkOutput("avg_hold", {24'd0, avg}, {24'd0, lastExp.avg});
    checkOutput("sat_hold", {31'd0, sat}, {31'd0, lastExp.sat});
    runDivision(22'd10, 14'd5, -5);
    runDivision(22'd123, 14'd0, -5);
    checkOutput("dz_hold", {31'd0, div_zero}, 32'd1);
    runDivision(22'd50, 14'd5, -5);
    runDivision(22'd3000, 14'd12, 5);
    for (int i = 0; i < 4; i++) begin
      runDivision(22'($urandom), 14'($urandom_range(1, 16383)), -5);
    end

    // Abort a division with reset and make sure it never completes.
    applyStimulus(22'd5000, 14'd7);
    repeat (10) @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("abort_busy", {31'd0, busy}, 32'd0);
    checkOutput("abort_avg", {24'd0, avg}, 32'd0);
    checkOutput("abort_done", {31'd0, done}, 32'd0);
    scoreboard.delete();
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (30) @(negedge clk);
    checkOutput("no_late_done", {31'd0, done}, 32'd0);
    runDivision(22'd2550, 14'd10, -5);
    checkOutput("sb_empty", 32'(scoreboard.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule

// File: doc/pixel_mean_divider.md
Name: pixel_mean_divider

Overview:
- Consumes the 22-bit running pixel sum produced by the 8-bit pixel accumulator, plus the pixel count for the same window.
- Computes the mean pixel value, sum / count, truncated to 8 bits.
- Uses a sequential restoring divider, one quotient bit per clock.
- Sits between the accumulator and the sorting/ranking logic. It is the reader side of the accumulator's SUM interface and produces one 8-bit mean per image/block.

Parameters:
- SUM_W, 22, width of the dividend (accumulator sum).
- CNT_W, 14, width of the divisor (pixel count; 255*(2^14-1) < 2^22).
- OUT_W, 8, width of the mean output.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled high in IDLE, latches sum_in/count_in.
- sum_in  input  SUM_W  dividend (accumulator SUM).
- count_in  input  CNT_W  divisor (pixels accumulated).
- busy  output  1  high while a division is in progress.
- done  output  1  one-cycle pulse when avg/sat/div_zero are valid.
- avg  output  OUT_W  truncated mean; held until the next done.
- sat  output  1  quotient exceeded 2^OUT_W-1; avg clamped to all-ones.
- div_zero  output  1  count_in was 0 on the accepted start.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; busy=0, done=0, avg=0, sat=0, div_zero=0. Internal remainder, quotient, divisor and bit counter are cleared.
- States: IDLE, DIV, FIN.
- IDLE, start=1, count_in!=0, at edge k:
  - latch dividend=sum_in, divisor=count_in, remainder=0, bit counter=SUM_W-1;
  - busy=1; sat/div_zero cleared; go to DIV.
- IDLE, start=1, count_in==0, at edge k: avg=all-ones, div_zero=1, sat=0, done=1 at edge k (one cycle), busy stays 0, stay IDLE.
- DIV, edges k+1 .. k+SUM_W (one bit per edge, MSB first):
  - r' = {remainder, dividend MSB};
  - if r' >= divisor: remainder=r'-divisor, q bit=1; else remainder=r', q bit=0;
  - shift dividend left;
  - remainder is CNT_W+1 bits wide to avoid compare overflow.
- The last bit is computed at edge k+SUM_W (k+22), and the state moves to FIN.
- FIN, edge k+SUM_W+1 (k+23):
  - if quotient > 2^OUT_W-1: avg=all-ones, sat=1; else avg=quotient[OUT_W-1:0];
  - done=1 for exactly this cycle; busy=0; go to IDLE.
- Latency: start at edge k gives done high after edge k+23. Throughput: one division per 24 cycles; start may be reasserted in the cycle done is high (sampled in IDLE at the next edge).
- start while busy (DIV/FIN) is ignored; operands are not re-latched.
- sum_in/count_in may change freely after the accepting edge.
- avg, sat and div_zero hold between done pulses. sat and div_zero clear on the next accepted start.
- Remainder is discarded (truncating division, no rounding).
- Reset mid-division: immediate return to IDLE with all outputs zero; no done is issued for the aborted operation.

Test Plan:
- sum_in=1000, count_in=8, start 1 cycle -> busy 1 for 23 cycles; done after edge k+23; avg=125, sat=0, div_zero=0.
- sum_in=4177665 (255*16383), count_in=16383 -> avg=255, sat=0; then sum_in=7, count_in=3 -> avg=2 (truncation).
- sum_in=600, count_in=2 -> quotient 300, avg=255, sat=1; next start with sum_in=10, count_in=5 -> avg=2, sat=0.
- count_in=0, sum_in=123 -> done at the accepting edge, avg=255, div_zero=1, busy never high; next valid start clears div_zero.
- start pulsed again at cycle k+5 with different operands -> ignored; result still matches the first operands.
- reset driven low at cycle k+10 -> busy/avg/done drop to 0 immediately, no later done. After release, a new start with sum_in=2550, count_in=10 -> avg=255 at k'+23.
